// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one binary-to-Gray stage among NUM_REQ sources.
// Result is held in a single registered valid/ready slot tagged with the source ID.
module gray_conv_arbiter #(
    parameter int WIDTH   = 4,
    parameter int NUM_REQ = 4,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                     Clk_I,
    input  logic                     Rst_N_I,
    input  logic [NUM_REQ-1:0]       Req_I,
    input  logic [NUM_REQ*WIDTH-1:0] Bin_I,
    output logic [NUM_REQ-1:0]       Gnt_O,
    output logic                     Valid_O,
    input  logic                     Ready_I,
    output logic [WIDTH-1:0]         Gray_O,
    output logic [ID_W-1:0]          Id_O
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic [ID_W-1:0]  id_q, id_d;

    logic             accept;
    logic             found;
    logic [ID_W-1:0]  gidx;
    logic [WIDTH-1:0] bin_g;
    logic             grant;

    assign accept = (state_q == EMPTY) || Ready_I;

    always_comb begin
        found = 1'b0;
        gidx  = '0;
        bin_g = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int idx;
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (!found && Req_I[idx]) begin
                found = 1'b1;
                gidx  = ID_W'(idx);
                bin_g = Bin_I[idx*WIDTH +: WIDTH];
            end
        end
    end

    // Gated by the raw reset so no grant is ever seen while reset is held.
    assign grant = Rst_N_I && accept && found;

    always_comb begin
        Gnt_O = '0;
        if (grant) begin
            Gnt_O[gidx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gray_d  = gray_q;
        id_d    = id_q;
        if (grant) begin
            state_d = FULL;
            gray_d  = bin_g ^ (bin_g >> 1);
            id_d    = gidx;
            ptr_d   = (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
        end else if (state_q == FULL && Ready_I) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge Clk_I or negedge Rst_N_I) begin
        if (!Rst_N_I) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            gray_q  <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gray_q  <= gray_d;
            id_q    <= id_d;
        end
    end

    assign Valid_O = (state_q == FULL);
    assign Gray_O  = gray_q;
    assign Id_O    = id_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Scoreboard bench for gray_conv_arbiter: model grants, queue of expected words.
// Inputs change just after the falling edge; checks run 1ns later.
module tb_gray_conv_arbiter;

    logic        Clk_I;
    logic        Rst_N_I;
    logic [3:0]  Req_I;
    logic [15:0] Bin_I;
    logic [3:0]  Gnt_O;
    logic        Valid_O;
    logic        Ready_I;
    logic [3:0]  Gray_O;
    logic [1:0]  Id_O;

    gray_conv_arbiter #(.WIDTH(4), .NUM_REQ(4)) dut (
        .Clk_I   (Clk_I),
        .Rst_N_I (Rst_N_I),
        .Req_I   (Req_I),
        .Bin_I   (Bin_I),
        .Gnt_O   (Gnt_O),
        .Valid_O (Valid_O),
        .Ready_I (Ready_I),
        .Gray_O  (Gray_O),
        .Id_O    (Id_O)
    );

    initial Clk_I = 1'b0;
    always #5 Clk_I = ~Clk_I;

    int n_cmp = 0;
    int n_err = 0;
    int m_ptr = 0;
    logic m_valid = 1'b0;
    logic [5:0] sb[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        logic [3:0] eg;
        logic [3:0] b;
        logic [5:0] e;
        int g;
        #1;
        eg = '0;
        g  = -1;
        if (Rst_N_I && (!m_valid || Ready_I)) begin
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = (m_ptr + k) % 4;
                if (g < 0 && Req_I[idx]) g = idx;
            end
        end
        if (g >= 0) eg[g] = 1'b1;
        check("gnt", Gnt_O, eg);
        check("valid", Valid_O, m_valid);
        if (Valid_O && Ready_I) begin
            if (sb.size() == 0) begin
                check("sb_underrun", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check("gray", Gray_O, e[3:0]);
                check("id", Id_O, e[5:4]);
            end
        end
        if (g >= 0) begin
            b = Bin_I[g*4 +: 4];
            sb.push_back({2'(g), b ^ (b >> 1)});
            m_ptr   = (g + 1) % 4;
            m_valid = 1'b1;
        end else if (m_valid && Ready_I) begin
            m_valid = 1'b0;
        end
        @(posedge Clk_I);
        @(negedge Clk_I);
    endtask

    task automatic do_reset();
        Rst_N_I = 1'b0;
        Req_I   = 4'hF;
        Ready_I = 1'b1;
        repeat (2) begin
            #1;
            check("rst_gnt", Gnt_O, 0);
            check("rst_valid", Valid_O, 0);
            check("rst_gray", Gray_O, 0);
            check("rst_id", Id_O, 0);
            @(posedge Clk_I);
            @(negedge Clk_I);
        end
        Rst_N_I = 1'b1;
        Req_I   = '0;
        m_ptr   = 0;
        m_valid = 1'b0;
        sb.delete();
    endtask

    logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    logic [3:0] g0;
    logic [1:0] i0;

    initial begin
        Rst_N_I = 1'b1;
        Req_I   = '0;
        Bin_I   = '0;
        Ready_I = 1'b0;
        @(negedge Clk_I);

        do_reset();
        Req_I   = 4'b0010;
        Bin_I   = 16'h0_0_B_0;
        Ready_I = 1'b1;
        cycle();
        Req_I = '0;
        check("t2_valid", Valid_O, 1);
        check("t2_gray", Gray_O, 4'b1110);
        check("t2_id", Id_O, 1);
        cycle();

        do_reset();
        Req_I   = 4'b1111;
        Bin_I   = 16'h5A3C;
        Ready_I = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("t3_id", Id_O, i % 4);
            check("t3_valid", Valid_O, 1);
            Bin_I = Bin_I + 16'h1357;
        end

        cycle();
        check("t4_id2", Id_O, 2);
        Req_I = 4'b1001;
        cycle();
        check("t4_id3", Id_O, 3);
        cycle();
        check("t4_id0", Id_O, 0);

        Req_I   = 4'b1111;
        Ready_I = 1'b0;
        g0 = Gray_O;
        i0 = Id_O;
        repeat (3) begin
            cycle();
            check("t5_gray_hold", Gray_O, g0);
            check("t5_id_hold", Id_O, i0);
            check("t5_valid_hold", Valid_O, 1);
        end
        Ready_I = 1'b1;
        cycle();
        check("t5_next_id", Id_O, 1);
        Req_I = '0;
        cycle();
        cycle();

        do_reset();
        Req_I   = 4'b0001;
        Ready_I = 1'b1;
        for (int v = 0; v < 16; v++) begin
            Bin_I[3:0] = 4'(v);
            cycle();
            check("t6_gray", Gray_O, gtab[v]);
        end
        Req_I = '0;
        cycle();

        Req_I   = 4'b0001;
        Ready_I = 1'b0;
        cycle();
        cycle();
        check("t7_full", Valid_O, 1);
        #2;
        Rst_N_I = 1'b0;
        #1;
        check("t7_async_valid", Valid_O, 0);
        check("t7_async_gnt", Gnt_O, 0);
        m_ptr   = 0;
        m_valid = 1'b0;
        sb.delete();
        @(negedge Clk_I);
        Rst_N_I = 1'b1;
        Req_I   = 4'b1111;
        Ready_I = 1'b1;
        cycle();
        check("t7_first_id", Id_O, 0);
        Req_I = '0;
        cycle();
        cycle();
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected end before 100000");
        $fatal(1);
    end

endmodule

// File: doc/gray_conv_arbiter.md
Name: gray_conv_arbiter

Overview:
Round-robin arbiter and sequencer that shares one binary-to-Gray conversion stage among NUM_REQ requesters. Each requester presents a binary word with a request. The block grants one requester per cycle and converts the word (Gray = Bin ^ (Bin >> 1)). It returns the result on a single registered valid/ready output tagged with the requester ID. It sits between multiple pointer/counter sources and a single downstream Gray-code consumer (e.g. CDC synchronizer bank).

Parameters:
WIDTH, 4, width of each binary input word and of the Gray output.
NUM_REQ, 4, number of requesters (>=2). Derived localparam ID_W = $clog2(NUM_REQ).

Ports:
Clk_I  input  1  clock; all state updates on rising edge.
Rst_N_I  input  1  reset; asynchronous assert, active-low. One clock, one reset (fixed).
Req_I  input  NUM_REQ  per-requester request. Bit r belongs to requester r.
Bin_I  input  NUM_REQ*WIDTH  packed binary words. Requester r uses bits [r*WIDTH +: WIDTH].
Gnt_O  output  NUM_REQ  one-hot grant, combinational. Request r is accepted at the edge where Req_I[r] && Gnt_O[r].
Valid_O  output  1  output slot holds a converted word.
Ready_I  input  1  downstream accepts the word at the edge where Valid_O && Ready_I.
Gray_O  output  WIDTH  Gray code of the accepted word.
Id_O  output  ID_W  index of the requester whose word is in Gray_O.

Behaviour:
- Reset (Rst_N_I low, asynchronous):
  - Valid_O=0, Gray_O=0, Id_O=0.
  - Round-robin pointer=0, FSM=EMPTY.
  - Gnt_O forced to 0 while reset is asserted.
- FSM states:
  - EMPTY: Valid_O=0.
  - FULL: Valid_O=1.
- Accept condition: accept = (state==EMPTY) || (Valid_O && Ready_I).
  - Gnt_O is all zeros unless accept and at least one Req_I bit is set.
- Arbitration:
  - Search Req_I starting at the pointer, ascending, wrapping modulo NUM_REQ.
  - The first set bit g is granted: Gnt_O = 1<<g.
  - Pointer updates to (g+1) mod NUM_REQ only on an edge where a grant occurs; otherwise it holds.
- Capture on grant edge:
  - Gray_O <= Bin_g ^ (Bin_g >> 1), where Bin_g is the granted word.
  - Id_O <= g. FSM -> FULL.
  - Latency: request granted in cycle N -> Valid_O and result visible in cycle N+1.
- Transitions:
  - FULL with Ready_I=1 and no grant -> EMPTY; Gray_O and Id_O keep their last values.
  - FULL with Ready_I=1 and a grant -> stays FULL with new data. Throughput is one word per cycle.
  - FULL with Ready_I=0 -> Gray_O, Id_O, Valid_O and the pointer all hold; Gnt_O=0.
- Requester rules:
  - A requester holds Req_I and Bin_I stable until it is granted.
  - Deasserting Req_I before a grant is legal and has no side effect.
- No starvation: each continuously requesting requester is granted within NUM_REQ accepted transfers.
- Reset mid-operation: all state clears immediately, and any held word is dropped. Arbitration restarts from requester 0.

Test Plan:
1. Reset with Req_I=4'b1111 and Ready_I=1 -> Gnt_O=0, Valid_O=0, Gray_O=0, Id_O=0 throughout reset.
2. Only Req_I[1]=1 with Bin=4'b1011, Ready_I=1 -> Gnt_O=4'b0010 that cycle. Next cycle: Valid_O=1, Gray_O=4'b1110, Id_O=1.
3. Req_I=4'b1111 held, Ready_I=1 -> Id_O sequence 0,1,2,3,0,1 on consecutive cycles, Valid_O continuously 1.
4. After requester 2 is granted, Req_I=4'b1001 -> requester 3 is granted first, then requester 0.
5. Valid_O=1, Ready_I=0 for 3 cycles with requests pending -> Gnt_O=0 and outputs stable. Ready_I=1 -> the same edge retires the word and grants the next requester.
6. Requester 0 sweeps Bin 0..15 -> Gray_O = 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8.
7. Assert Rst_N_I low mid-cycle while FULL and Ready_I=0 -> Valid_O drops immediately without waiting for a clock edge. After release, the first grant goes to requester 0 when Req_I=4'b1111.
